// File: rtl/cdb_arb.sv
// Common data bus arbiter: round-robin grant among execution units, one registered broadcast per cycle.
// Optional starvation override enabled by defining CDB_ARB_STARVE_EN.
module cdb_arb #(
  parameter int NREQ       = 3,
  parameter int TAG_W      = 4,
  parameter int DATA_W     = 32,
  parameter int STARVE_LIM = 7,
  localparam int SRC_W     = $clog2(NREQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [NREQ-1:0]          req_vld,
  input  logic [NREQ*TAG_W-1:0]    req_tag,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          req_rdy,
  output logic                     cdb_vld,
  output logic [TAG_W-1:0]         cdb_tag,
  output logic [DATA_W-1:0]        cdb_data,
  output logic [SRC_W-1:0]         cdb_src
);

  if (NREQ < 2 || NREQ > 8 || STARVE_LIM < 1 || STARVE_LIM > 15) begin : g_param_err
    $error("cdb_arb: illegal NREQ or STARVE_LIM");
  end

  logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              cdb_vld_q, cdb_vld_d;
  logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
  logic [SRC_W-1:0]  cdb_src_q, cdb_src_d;

  logic              rr_hit;
  logic [SRC_W-1:0]  rr_idx;
  logic              gnt_vld;
  logic [SRC_W-1:0]  gnt_idx;
  logic [NREQ-1:0]   gnt_oh;

  // Round-robin search from rr_ptr; descending loop so the nearest valid requester wins.
  always_comb begin
    int pos;
    rr_hit = 1'b0;
    rr_idx = '0;
    pos    = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      pos = int'(rr_ptr_q) + k;
      if (pos >= NREQ) pos = pos - NREQ;
      if (req_vld[SRC_W'(pos)]) begin
        rr_hit = 1'b1;
        rr_idx = SRC_W'(pos);
      end
    end
  end

`ifdef CDB_ARB_STARVE_EN
  logic [NREQ-1:0][3:0] wait_q, wait_d;
  logic                 starve_hit;
  logic [SRC_W-1:0]     starve_idx;

  // Lowest-index starving unit takes priority over the round-robin choice.
  always_comb begin
    starve_hit = 1'b0;
    starve_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_vld[k] && (wait_q[k] >= 4'(STARVE_LIM))) begin
        starve_hit = 1'b1;
        starve_idx = SRC_W'(k);
      end
    end
  end

  always_comb begin
    wait_d = wait_q;
    for (int k = 0; k < NREQ; k++) begin
      if (!req_vld[k] || gnt_oh[k])
        wait_d[k] = 4'd0;
      else if (wait_q[k] != 4'hF)
        wait_d[k] = wait_q[k] + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) wait_q <= '0;
    else     wait_q <= wait_d;
  end

  always_comb gnt_idx = starve_hit ? starve_idx : rr_idx;
`else
  always_comb gnt_idx = rr_idx;
`endif

  always_comb begin
    gnt_vld = rr_hit && !flush && !rst;
    gnt_oh  = gnt_vld ? (NREQ'(1) << gnt_idx) : '0;
  end

  assign req_rdy = gnt_oh;

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    cdb_vld_d  = gnt_vld;
    cdb_tag_d  = cdb_tag_q;
    cdb_data_d = cdb_data_q;
    cdb_src_d  = cdb_src_q;
    if (gnt_vld) begin
      rr_ptr_d  = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + SRC_W'(1);
      cdb_src_d = gnt_idx;
      for (int k = 0; k < NREQ; k++) begin
        if (int'(gnt_idx) == k) begin
          cdb_tag_d  = req_tag[k*TAG_W +: TAG_W];
          cdb_data_d = req_data[k*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q   <= '0;
      cdb_vld_q  <= 1'b0;
      cdb_tag_q  <= '0;
      cdb_data_q <= '0;
      cdb_src_q  <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      cdb_vld_q  <= cdb_vld_d;
      cdb_tag_q  <= cdb_tag_d;
      cdb_data_q <= cdb_data_d;
      cdb_src_q  <= cdb_src_d;
    end
  end

  assign cdb_vld  = cdb_vld_q;
  assign cdb_tag  = cdb_tag_q;
  assign cdb_data = cdb_data_q;
  assign cdb_src  = cdb_src_q;

endmodule

// File: doc/cdb_arb.md
CDB_ARB -- requirements
Module: cdb_arb

Interface
REQ-001 Parameter NREQ, default 3: number of execution-unit requesters (index 0=ALU, 1=MDU, 2=LSU); legal range 2..8.
REQ-002 Parameter TAG_W, default 4: ROB/rename tag width.
REQ-003 Parameter DATA_W, default 32: result data width.
REQ-004 Parameter STARVE_LIM, default 7: wait-cycle threshold for starvation override; legal range 1..15.
REQ-005 clk  in  1  clock; all state changes on the rising edge.
REQ-006 rst  in  1  reset; synchronous, active-high.
REQ-007 flush  in  1  pipeline flush; discards the pending broadcast.
REQ-008 req_vld  in  NREQ  per-unit result valid.
REQ-009 req_tag  in  NREQ*TAG_W  per-unit destination tag; unit i occupies bits [i*TAG_W +: TAG_W].
REQ-010 req_data  in  NREQ*DATA_W  per-unit result; unit i occupies bits [i*DATA_W +: DATA_W].
REQ-011 req_rdy  out  NREQ  one-hot grant; unit i's result is accepted in any cycle where req_vld[i] and req_rdy[i] are both high.
REQ-012 cdb_vld  out  1  broadcast valid, registered.
REQ-013 cdb_tag  out  TAG_W  broadcast tag, registered.
REQ-014 cdb_data  out  DATA_W  broadcast data, registered.
REQ-015 cdb_src  out  $clog2(NREQ)  index of the unit that produced the current broadcast, registered.

Function
REQ-016 Shared resource: the single common data bus, which the RS, RFU and ROB all snoop; at most one broadcast per cycle.
REQ-017 req_rdy is combinational from req_vld, the round-robin pointer and the starvation state; at most one bit is high; req_rdy[i] is never high while req_vld[i] is low.
REQ-018 Round-robin: the search starts at pointer rr_ptr and wraps modulo NREQ; the first valid requester found is granted.
REQ-019 After a grant to unit g, rr_ptr takes (g+1) mod NREQ on the next edge; with no grant, rr_ptr holds.
REQ-020 Latency: a grant in cycle N produces cdb_vld=1 in cycle N+1, with the granted tag, data and index.
REQ-021 In any cycle without a grant, cdb_vld is 0 on the next edge; cdb_tag, cdb_data and cdb_src hold their previous values.
REQ-022 The bus has no backpressure; a broadcast lasts exactly one cycle.
REQ-023 If req_vld is all-zero, req_rdy is all-zero.
REQ-024 Flush: while flush=1, req_rdy is forced to zero and cdb_vld is 0 on the next edge.
REQ-025 Flush does not clear rr_ptr.
REQ-026 A flush coincident with a pending broadcast suppresses it: cdb_vld is 0 in the cycle after flush.
REQ-027 The design is fully parameterised: no hard-coded unit count.

Reset
REQ-028 On rst: rr_ptr=0, cdb_vld=0, cdb_tag=0, cdb_data=0, cdb_src=0, and all wait counters=0.
REQ-029 req_rdy is all-zero during any cycle in which rst=1.
REQ-030 Reset asserted mid-stream drops the pending broadcast; it is not replayed.

Configuration
REQ-031 Macro CDB_ARB_STARVE_EN, when defined, adds one 4-bit saturating wait counter per unit.
REQ-032 Wait counter i increments on every cycle where req_vld[i]=1 and req_rdy[i]=0.
REQ-033 Wait counter i clears on a grant to unit i, and whenever req_vld[i]=0.
REQ-034 Any unit whose counter is at or above STARVE_LIM overrides round-robin; among such units the lowest index wins; rr_ptr still updates per REQ-019.
REQ-035 Without CDB_ARB_STARVE_EN: the counters are absent and arbitration is pure round-robin.

Verification
REQ-036 Reset sequence, then req_vld=3'b111 held 6 cycles -> grants 0,1,2,0,1,2; cdb_src matches each grant one cycle later; cdb_vld continuously 1.
REQ-037 Single requester: req_vld=3'b100, tag=4'hA, data=32'hDEADBEEF for 1 cycle -> req_rdy=3'b100 the same cycle; the next cycle cdb_vld=1, cdb_tag=4'hA, cdb_data=32'hDEADBEEF, cdb_src=2.
REQ-038 Flush: grant to unit 1 in cycle N with flush=1 in cycle N -> req_rdy=0 in cycle N and cdb_vld=0 in cycle N+1. Separately, grant in cycle N and flush in cycle N+1 -> cdb_vld=1 in cycle N+1 and cdb_vld=0 in cycle N+2.
REQ-039 Mid-stream reset: rst pulsed while cdb_vld=1 -> the next cycle cdb_vld=0 and rr_ptr=0; with req_vld=3'b011 afterwards, the first grant goes to unit 0.
REQ-040 With CDB_ARB_STARVE_EN and STARVE_LIM=2: force unit 2 to lose for 2 cycles (rr_ptr set so that 0 and 1 win) -> unit 2 is granted on the third cycle regardless of rr_ptr. Without the macro, the same stimulus follows pure round-robin order.
REQ-041 Bench assertions, checked every cycle: req_rdy is one-hot0; req_rdy is a subset of req_vld; the number of cdb_vld pulses equals the number of accepted handshakes minus those suppressed by flush or reset.
